// File: rtl/cp0_intc.sv
// Coprocessor-0 with Status/Cause/EPC, a Status enable nest stack, synchronised
// masked interrupt lines, an optional Count/Compare timer and a registered int_req.
module cp0_intc #(
    parameter int IRQ_NUM    = 6,
    parameter int NEST_DEPTH = 3,
    parameter int TIMER_EN   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic               eret,
    input  logic               exception,
    input  logic [4:0]         cause,
    input  logic [4:0]         addr,
    input  logic [31:0]        data,
    input  logic [31:0]        pc,
    input  logic [IRQ_NUM-1:0] irq,
    output logic [31:0]        rdata,
    output logic [31:0]        status,
    output logic [31:0]        exc_addr,
    output logic               int_req,
    output logic               timer_irq
);

    localparam int SW = 5 * NEST_DEPTH;

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    logic [SW-1:0]      stack_q;
    logic [IRQ_NUM-1:0] im_q;
    logic [IRQ_NUM-1:0] sync1_q;
    logic [IRQ_NUM-1:0] ip_q;
    logic [4:0]         exc_code_q;
    logic [31:0]        epc_q;
    logic [31:0]        count_q;
    logic [31:0]        compare_q;
    logic               ti_q;
    logic               int_req_q;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic pending;
    logic [31:0] status_w;
    logic [31:0] cause_w;

    assign wr_count   = mtc0 && (addr == A_COUNT);
    assign wr_compare = mtc0 && (addr == A_COMPARE);
    assign wr_status  = mtc0 && (addr == A_STATUS);
    assign wr_cause   = mtc0 && (addr == A_CAUSE);
    assign wr_epc     = mtc0 && (addr == A_EPC);

    // Status/Cause/EPC: a taken exception overrides any coincident mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_q    <= SW'(5'h1F);
            im_q       <= '1;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else if (exception) begin
            stack_q    <= stack_q << 5;
            exc_code_q <= cause;
            epc_q      <= pc;
        end else begin
            if (eret) begin
                stack_q <= stack_q >> 5;
            end else if (wr_status) begin
                stack_q <= data[SW-1:0];
            end
            if (wr_status) begin
                im_q <= data[24 +: IRQ_NUM];
            end
            if (wr_cause) begin
                exc_code_q <= data[6:2];
            end
            if (wr_epc) begin
                epc_q <= data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            ip_q    <= '0;
        end else begin
            sync1_q <= irq;
            ip_q    <= sync1_q;
        end
    end

    generate
        if (TIMER_EN != 0) begin : g_timer
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q   <= '0;
                    compare_q <= '1;
                    ti_q      <= 1'b0;
                end else begin
                    count_q <= wr_count ? data : count_q + 32'd1;
                    if (wr_compare) begin
                        compare_q <= data;
                    end
                    // A Compare write clears TI even if a match happens this edge.
                    if (wr_compare) begin
                        ti_q <= 1'b0;
                    end else if (count_q == compare_q) begin
                        ti_q <= 1'b1;
                    end
                end
            end
        end else begin : g_no_timer
            assign count_q   = '0;
            assign compare_q = '0;
            assign ti_q      = 1'b0;
        end
    endgenerate

    // The timer shares the top mask bit with the highest external line.
    assign pending = (|(ip_q & im_q)) | (ti_q & im_q[IRQ_NUM-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_req_q <= 1'b0;
        end else begin
            int_req_q <= !(exception || eret) && stack_q[0] && pending;
        end
    end

    always_comb begin
        status_w                 = '0;
        status_w[SW-1:0]         = stack_q;
        status_w[24 +: IRQ_NUM]  = im_q;
        cause_w                  = '0;
        cause_w[6:2]             = exc_code_q;
        cause_w[8 +: IRQ_NUM]    = ip_q;
        cause_w[30]              = ti_q;
    end

    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (addr)
                A_COUNT:   rdata = count_q;
                A_COMPARE: rdata = compare_q;
                A_STATUS:  rdata = status_w;
                A_CAUSE:   rdata = cause_w;
                A_EPC:     rdata = epc_q;
                default:   rdata = '0;
            endcase
        end
    end

    assign status    = status_w;
    assign exc_addr  = epc_q;
    assign int_req   = int_req_q;
    assign timer_irq = ti_q;

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised coprocessor-0 for the 54-instruction CPU.
- Keeps everything the existing CP0 does: Status/Cause/EPC, mfc0/mtc0, and an exception/eret status push-pop.
- Adds:
  - a configurable-depth Status nest stack;
  - IRQ_NUM synchronised external interrupt lines with a per-line mask;
  - a Count/Compare timer with a timer interrupt;
  - a registered int_req output to the pipeline control.
- Sits beside the register file; the control unit raises `exception` with cause=0 when it takes int_req.

Parameters:
- IRQ_NUM, 6, number of external interrupt lines (1..8).
- NEST_DEPTH, 3, number of 5-bit Status enable fields in the nest stack (1..4).
- TIMER_EN, 1, 1 = Count/Compare/TI implemented; 0 = those registers read 0, TI never set.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mfc0  in  1  read strobe
- mtc0  in  1  write strobe
- eret  in  1  exception return
- exception  in  1  exception taken this cycle
- cause  in  5  ExcCode of the exception (0 = interrupt)
- addr  in  5  CP0 register number
- data  in  32  mtc0 write data
- pc  in  32  PC to save in EPC
- irq  in  IRQ_NUM  asynchronous level interrupt requests
- rdata  out  32  mfc0 read data; 0 when mfc0=0
- status  out  32  current Status
- exc_addr  out  32  current EPC
- int_req  out  1  registered interrupt request
- timer_irq  out  1  current Cause.TI

Behaviour:
- Register map (all other addresses read 0, writes ignored): Count=9, Compare=11, Status=12, Cause=13, EPC=14.
- Status layout:
  - [5*NEST_DEPTH-1:0] nest stack; field k = bits [5k+4:5k]; field 0 is current, and its bit0 = IE.
  - [24+IRQ_NUM-1:24] IM, the interrupt mask.
  - All other bits read 0.
- Cause layout:
  - [6:2] ExcCode.
  - [8+IRQ_NUM-1:8] IP, read-only; this is the synchroniser output.
  - [30] TI.
  - Others read 0.
- Reset (rst_n low, asynchronous):
  - Status field0=5'b11111, other fields 0, IM all ones.
  - Cause=0, EPC=0, Count=0, Compare=32'hFFFFFFFF.
  - Synchronisers 0, int_req=0, rdata=0.
- Reads are combinational from current register state; a same-cycle write is not visible until the next cycle.
- irq passes a 2-flop synchroniser: a change on irq is visible in IP two edges later.
- Exception (edge):
  - stack <<= 5, field0 = 0, top field discarded;
  - ExcCode <= cause;
  - EPC <= pc.
- eret (edge): stack >>= 5, top field zero-filled. If exception is also asserted, eret is ignored.
- mtc0 with exception in the same cycle:
  - a write to Status, Cause or EPC is dropped;
  - a write to Count or Compare still applies.
- mtc0 write rules:
  - Cause: writes ExcCode only.
  - Status: writes stack and IM bits only.
  - EPC: full 32 bits.
- Timer (TIMER_EN=1):
  - Count increments by 1 every cycle and wraps FFFFFFFF→0.
  - mtc0 Count loads data; no increment that cycle.
  - TI sets on the edge after Count==Compare.
  - mtc0 Compare loads and clears TI; clear wins over a simultaneous set.
- int_req (registered):
  - next = IE & |((IP & IM) | TI-contribution), where the TI contribution is gated by IM[IRQ_NUM-1].
  - Forced 0 on any edge where exception or eret is asserted.
- Outputs: timer_irq = TI; status/exc_addr are direct register views.

Test Plan:
- Reset with rst_n low mid-cycle → status=0x3F00001F (IRQ_NUM=6), exc_addr=0, rdata=0, int_req=0, Compare read = FFFFFFFF.
- exception cause=5'd8, pc=0x00400020 with field0=1F → status[9:5]=1F, status[4:0]=0, Cause read=0x20, exc_addr=0x00400020; then eret → status[4:0]=1F.
- Four nested exceptions with NEST_DEPTH=3, then three erets → the original field is lost after the 3rd push and field0=0 at the end; exception and eret in the same cycle → push only.
- Assert irq[2] with IE=1, IM[2]=1 → IP[10] reads 1 after 2 edges and int_req=1 one edge later; IM[2]=0 → int_req stays 0.
- mtc0 Compare=5, mtc0 Count=0 → TI=1 on the edge after Count==5 and timer_irq=1; mtc0 Compare=100 → TI=0; Count=FFFFFFFF wraps to 0.
- mtc0 Status coincident with exception → the exception result wins; mtc0 Count coincident with exception → Count loads data.
